// File: rtl/tog_hs_pkg.sv
// Shared types and default widths for the toggle-handshake responder.
// Holds the responder FSM state encoding and the parameter defaults.
// No logic.
package tog_hs_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } tog_hs_state_t;

    localparam int TOG_DATA_W   = 8;
    localparam int TOG_CNT_W    = 8;
    localparam int TOG_SYNC_MIN = 2;

endpackage

// File: rtl/tog_sync.sv
// Purpose: N-stage synchronizer for an async toggle plus prev register and XOR transition detect.
// Latency: a change on d reaches q_s after STAGES clk edges; tog_edge is high for the cycle after that.
// Backpressure: none; tog_edge is a single-cycle pulse per level change and is never held.
//   Ports: clk, clr_n (async active-low), d (async toggle in),
//          q_s (synchronized level), tog_edge (q_s differs from its previous value).
module tog_sync
    import tog_hs_pkg::*;
#(
    parameter int STAGES = TOG_SYNC_MIN
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q_s,
    output logic tog_edge
);

    // Stage counts below the metastability minimum are raised to it.
    localparam int N = (STAGES < TOG_SYNC_MIN) ? TOG_SYNC_MIN : STAGES;

    logic [N-1:0] sync_q, sync_d;
    logic         prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
        prev_d = sync_q[N-1];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_s      = sync_q[N-1];
    assign tog_edge = sync_q[N-1] ^ prev_q;

endmodule

// File: rtl/tog_hs_responder.sv
// Purpose: responder side of a toggle req/ack link; presents each request on valid/ready, returns ack toggle.
// Latency: out_valid rises SYNC_STAGES+1 edges after req_tog changes; ack_tog flips on the accepting edge.
// Backpressure: out_valid/out_data hold while out_ready is low; a new toggle before ack is dropped and flagged.
//   Ports: clk, clr_n, req_tog/req_data (initiator side), out_valid/out_data/out_ready (consumer side),
//          ack_tog (back to initiator), evt_cnt (completed handshakes), proto_err/err_clr (sticky error).
module tog_hs_responder
    import tog_hs_pkg::*;
#(
    parameter int DATA_W      = TOG_DATA_W,
    parameter int SYNC_STAGES = TOG_SYNC_MIN,
    parameter int CNT_W       = TOG_CNT_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] req_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ack_tog,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic              proto_err,
    input  logic              err_clr
);

    logic tog_edge;
    // Only transitions of the request toggle matter; the level itself is not used.
    logic req_s_unused;

    tog_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .clr_n    (clr_n),
        .d        (req_tog),
        .q_s      (req_s_unused),
        .tog_edge (tog_edge)
    );

    tog_hs_state_t     state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              ack_tog_q, ack_tog_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
    logic              proto_err_q, proto_err_d;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ack_tog_d   = ack_tog_q;
        evt_cnt_d   = evt_cnt_q;
        proto_err_d = proto_err_q;

        if (err_clr) begin
            proto_err_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tog_edge) begin
                    out_data_d  = req_data;
                    out_valid_d = 1'b1;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A toggle here means the initiator did not wait for ack. The request is
                // dropped (edge consumed, payload untouched); the set overrides err_clr.
                if (tog_edge) begin
                    proto_err_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    ack_tog_d   = ~ack_tog_q;
                    evt_cnt_d   = evt_cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ack_tog_q   <= 1'b0;
            evt_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ack_tog_q   <= ack_tog_d;
            evt_cnt_q   <= evt_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ack_tog   = ack_tog_q;
    assign evt_cnt   = evt_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_tog_hs_responder.sv
// Directed bench for tog_hs_responder at default parameters (8-bit data, 2 sync stages, 8-bit count).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Each scenario task carries its own expected values.
module tb_tog_hs_responder;

    logic       clk;
    logic       clr_n;
    logic       req_tog;
    logic [7:0] req_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       ack_tog;
    logic [7:0] evt_cnt;
    logic       proto_err;
    logic       err_clr;

    int n_tests;
    int n_fail;

    tog_hs_responder #(
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_tog   (req_tog),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ack_tog   (ack_tog),
        .evt_cnt   (evt_cnt),
        .proto_err (proto_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic req_level);
        clr_n     = 1'b0;
        req_tog   = req_level;
        req_data  = 8'h00;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        tick(3);
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_tests++;
        if ({out_valid, ack_tog, proto_err} !== 3'b000 || out_data !== 8'h00 || evt_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ack=%b err=%b data=%h cnt=%0d, want all 0",
                     out_valid, ack_tog, proto_err, out_data, evt_cnt);
        end
        tick(4);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_no_valid: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_single();
        req_data  = 8'hA5;
        req_tog   = 1'b1;
        out_ready = 1'b1;
        tick(2);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_early: valid=%b after edge 2, want 0", out_valid);
        end
        tick(1);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack_tog !== 1'b0) begin
            n_fail++;
            $display("FAIL single_capture: valid=%b data=%h ack=%b, want 1 a5 0", out_valid, out_data, ack_tog);
        end
        tick(1);
        n_tests++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b1 || evt_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL single_accept: valid=%b ack=%b cnt=%0d, want 0 1 1", out_valid, ack_tog, evt_cnt);
        end
        // out_ready stays high while idle: nothing must happen.
        tick(4);
        n_tests++;
        if (out_valid !== 1'b0 || evt_cnt !== 8'd1 || out_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_ready_idle: valid=%b cnt=%0d data=%h, want 0 1 a5", out_valid, evt_cnt, out_data);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad       = 0;
        out_ready = 1'b0;
        req_data  = 8'h3C;
        req_tog   = 1'b0;
        tick(3);
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'h3C || ack_tog !== 1'b1) bad++;
            tick(1);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d held cycles wrong, want 0", bad);
        end
        out_ready = 1'b1;
        tick(1);
        n_tests++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b0 || evt_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_accept: valid=%b ack=%b cnt=%0d, want 0 0 2", out_valid, ack_tog, evt_cnt);
        end
    endtask

    task automatic test_proto_err();
        out_ready = 1'b0;
        req_data  = 8'h11;
        req_tog   = 1'b1;
        tick(5);
        req_data = 8'hFF;
        req_tog  = 1'b0;
        tick(3);
        n_tests++;
        if (proto_err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11) begin
            n_fail++;
            $display("FAIL perr_set: err=%b valid=%b data=%h, want 1 1 11", proto_err, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick(1);
        n_tests++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b1 || evt_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL perr_accept: valid=%b ack=%b cnt=%0d, want 0 1 3", out_valid, ack_tog, evt_cnt);
        end
        tick(5);
        n_tests++;
        if (out_valid !== 1'b0 || evt_cnt !== 8'd3 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL perr_dropped: valid=%b cnt=%0d err=%b, want 0 3 1", out_valid, evt_cnt, proto_err);
        end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_tests++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_clear: err=%b want 0", proto_err);
        end
    endtask

    // Re-toggle while waiting, timed so the detected edge lands on the accepting edge,
    // with err_clr asserted in that same cycle.
    task automatic test_simultaneous();
        // req_tog is 0 (matched by ack_tog=1 ^ ... levels: req=0 after previous test, ack=1).
        out_ready = 1'b0;
        req_data  = 8'h5A;
        req_tog   = 1'b1;
        tick(3);
        req_data = 8'h77;
        req_tog  = 1'b0;
        tick(2);
        n_tests++;
        if (out_valid !== 1'b1 || proto_err !== 1'b0 || out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL simul_pre: valid=%b err=%b data=%h, want 1 0 5a", out_valid, proto_err, out_data);
        end
        out_ready = 1'b1;
        err_clr   = 1'b1;
        tick(1);
        out_ready = 1'b0;
        err_clr   = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b0 || evt_cnt !== 8'd4 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_accept: valid=%b ack=%b cnt=%0d err=%b, want 0 0 4 1",
                     out_valid, ack_tog, evt_cnt, proto_err);
        end
        tick(5);
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL simul_consumed: valid=%b data=%h, want 0 5a", out_valid, out_data);
        end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic test_wrap();
        int bad;
        int timeouts;
        bad      = 0;
        timeouts = 0;
        do_reset(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int w;
            req_data = 8'(i);
            req_tog  = ~req_tog;
            w = 0;
            while (ack_tog !== req_tog && w < 10) begin
                tick(1);
                w++;
            end
            if (ack_tog !== req_tog) timeouts++;
            if (i == 254) begin
                n_tests++;
                if (evt_cnt !== 8'hFF || out_data !== 8'd254) begin
                    n_fail++;
                    $display("FAIL wrap_allones: cnt=%h data=%h, want ff fe", evt_cnt, out_data);
                end
            end
            if (evt_cnt !== 8'(i + 1)) bad++;
        end
        n_tests++;
        if (timeouts != 0) begin
            n_fail++;
            $display("FAIL wrap_ack_follows_req: %0d handshakes timed out, want 0", timeouts);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_count_step: %0d wrong counts, want 0", bad);
        end
        n_tests++;
        if (evt_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%h want 00", evt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        out_ready = 1'b1;
        req_data  = 8'h42;
        req_tog   = 1'b1;
        tick(4);
        out_ready = 1'b0;
        req_data  = 8'h43;
        req_tog   = 1'b0;
        tick(3);
        req_tog = 1'b1;
        tick(3);
        n_tests++;
        if (out_valid !== 1'b1 || ack_tog !== 1'b1 || evt_cnt !== 8'd1 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: valid=%b ack=%b cnt=%0d err=%b, want 1 1 1 1",
                     out_valid, ack_tog, evt_cnt, proto_err);
        end
        #2;
        clr_n   = 1'b0;
        req_tog = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || ack_tog !== 1'b0 || evt_cnt !== 8'd0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear: valid=%b ack=%b cnt=%0d err=%b, want 0 0 0 0",
                     out_valid, ack_tog, evt_cnt, proto_err);
        end
        tick(2);
        clr_n = 1'b1;
        tick(6);
        n_tests++;
        if (out_valid !== 1'b0 || evt_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_no_spurious: valid=%b cnt=%0d, want 0 0", out_valid, evt_cnt);
        end
    endtask

    task automatic test_release_high();
        do_reset(1'b1);
        req_data  = 8'hC3;
        out_ready = 1'b0;
        tick(2);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_high_early: valid=%b want 0", out_valid);
        end
        tick(1);
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL rel_high_valid: valid=%b data=%h, want 1 c3", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick(1);
        n_tests++;
        if (ack_tog !== 1'b1 || evt_cnt !== 8'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_high_ack: ack=%b cnt=%0d valid=%b, want 1 1 0", ack_tog, evt_cnt, out_valid);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_proto_err();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_release_high();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tog_hs_responder.md
Name: tog_hs_responder

Overview:
- Responder end of a toggle-encoded request/acknowledge handshake. The initiator's T flip-flop flips req_tog once per request.
- This block synchronizes req_tog and detects each transition. It presents the captured request data on a valid/ready interface, then returns a toggled ack_tog once the consumer accepts.
- It counts completed events and flags protocol violations, where the initiator toggles again before ack.
- It sits on the receiving side of any TFF-based event/toggle link.

Parameters:
- DATA_W, 8, width of request payload.
- SYNC_STAGES, 2, flops in req_tog synchronizer (minimum 2).
- CNT_W, 8, width of completed-event counter.

Ports:
- clk  input  1  single clock, rising-edge.
- clr_n  input  1  asynchronous active-low reset.
- req_tog  input  1  request toggle from initiator; each level change is one request.
- req_data  input  DATA_W  request payload; initiator holds it stable from before the toggle until ack_tog returns.
- out_valid  output  1  captured request available.
- out_data  output  DATA_W  captured payload.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high.
- ack_tog  output  1  acknowledge toggle back to initiator.
- evt_cnt  output  CNT_W  count of completed handshakes.
- proto_err  output  1  sticky protocol-violation flag.
- err_clr  input  1  synchronous clear of proto_err.

Behaviour:
- Reset (clr_n low, asynchronous) clears all of the following to 0:
  - sync flops and prev register
  - state (IDLE)
  - out_valid, out_data, ack_tog, evt_cnt, proto_err
- Synchronizer: req_tog passes through SYNC_STAGES flops to give req_s. The prev register holds the last req_s. edge = req_s XOR prev. prev <= req_s every cycle.
- Latency:
  - req_tog is first sampled changed at edge 1; out_valid goes high after edge SYNC_STAGES+1 (edge 3 at default).
  - After an out_valid/out_ready handshake, ack_tog flips at that same clock edge.
- State machine (2 states):
  - IDLE: on edge, out_data <= req_data, out_valid <= 1, move to WAIT. Otherwise hold.
  - WAIT: out_valid held high and out_data held stable. On out_valid and out_ready: out_valid <= 0, ack_tog <= ~ack_tog, evt_cnt <= evt_cnt+1, move to IDLE.
- Counter: evt_cnt wraps modulo 2^CNT_W with no saturation; all-ones + 1 = 0.
- Protocol error: edge detected while in WAIT.
  - proto_err <= 1.
  - The new request is dropped, not queued; out_data is not overwritten.
  - prev still updates.
- Simultaneous edge in WAIT and out_ready: the handshake completes normally (ack flips, count increments, return to IDLE) AND proto_err is set. The edge is consumed and no new out_valid is raised.
- err_clr and a new error in the same cycle: set wins, proto_err stays 1.
- out_data keeps its last captured value after handshake until the next capture.
- out_ready while out_valid is low: ignored.
- Reset mid-operation: any pending transfer is discarded with no ack. The initiator must be reset with it so that both toggle levels realign at 0.
- req_tog high at reset release: the sync chain sees a 0->1 change, which is treated as a legitimate new request.
- No combinational path from any input to any output.

Decomposition:
- Package tog_hs_pkg:
  - state enum type tog_hs_state_t {ST_IDLE, ST_WAIT}
  - default width constants TOG_DATA_W=8, TOG_CNT_W=8, TOG_SYNC_MIN=2
- Sub-module tog_sync (clk, clr_n, d, q_s, edge): N-stage synchronizer plus prev register and XOR edge detect. Parameter STAGES; async active-low reset clears all flops to 0.
- Top level holds the FSM, data capture, ack toggle, counter and error logic.

Test Plan:
- Single request: after reset, req_data=8'hA5, req_tog 0->1, out_ready=1 -> out_valid high after 3rd clk edge with out_data=A5; ack_tog 0->1 same edge out_valid falls; evt_cnt=1.
- Back-pressure: req_data=8'h3C, toggle, out_ready=0 for 10 cycles, then 1 -> out_valid and out_data=3C held all 10 cycles; ack_tog flips only on accept; evt_cnt +1.
- Protocol error: toggle with out_ready=0, toggle again 5 cycles later with req_data=8'hFF -> proto_err=1, out_data unchanged, single handshake on accept; err_clr pulse -> proto_err=0.
- Counter wrap: CNT_W=8, perform 256 complete handshakes alternating req_tog -> evt_cnt returns to 0; ack_tog equals req_tog after each.
- Reset mid-transfer: toggle, assert clr_n low while out_valid=1 -> out_valid, ack_tog, evt_cnt, proto_err all 0 immediately (asynchronous, before next clk edge); no spurious event after release with req_tog=0.
- Reset release with req_tog=1: release clr_n -> out_valid rises SYNC_STAGES+1 edges later; handshake flips ack_tog to 1.
